// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush and LM/SM micro-op sequencer for the
// 5-stage pipeline. Drives enable/clear of the four stage registers and the
// PC write enable. Control outputs are combinational (zero-cycle latency) from
// the sequencing state and this cycle's hazard inputs.
module pipe_hazard_ctrl #(
  parameter int unsigned K_W = 3
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  ld_use_hz,
  input  logic                  jmp_id,
  input  logic                  br_taken_ex,
  input  logic                  lmsm_start,
  input  logic [(2**K_W)-1:0]   lmsm_imm_8,
  output logic                  pc_en,
  output logic                  en_f2d,
  output logic                  en_d2e,
  output logic                  en_e2m,
  output logic                  en_m2w,
  output logic                  clr_f2d,
  output logic                  clr_d2e,
  output logic                  clr_e2m,
  output logic                  clr_m2w,
  output logic [K_W-1:0]        k_3,
  output logic [K_W-1:0]        lmsm_idx_3,
  output logic                  lmsm_active,
  output logic                  lmsm_last
);

  localparam int unsigned MASK_W = 2**K_W;

  typedef enum logic {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } state_t;

  state_t              state;
  logic [MASK_W-1:0]   mask;
  logic [K_W-1:0]      idx;

  logic [K_W-1:0]      mask_low;
  logic [K_W-1:0]      imm_low;
  logic                mask_one;
  logic                imm_one;
  logic                imm_multi;
  logic                start_ok;

  // Index of the lowest set bit (0 when the vector is empty)
  function automatic logic [K_W-1:0] lowest_bit(input logic [MASK_W-1:0] m);
    logic [K_W-1:0] r;
    r = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (m[i]) r = K_W'(i);
    end
    return r;
  endfunction

  // True when exactly one bit of the vector is set
  function automatic logic is_onehot(input logic [MASK_W-1:0] m);
    return (m != '0) && ((m & (m - MASK_W'(1))) == '0);
  endfunction

  // Mask decode shared by the sequencer and the output logic
  always_comb begin
    mask_low  = lowest_bit(mask);
    imm_low   = lowest_bit(lmsm_imm_8);
    mask_one  = is_onehot(mask);
    imm_one   = is_onehot(lmsm_imm_8);
    imm_multi = (lmsm_imm_8 != '0) && !imm_one;
    // LM/SM may start only in IDLE with no higher-priority event this cycle
    start_ok  = (state == IDLE) && lmsm_start && !clr && !br_taken_ex &&
                !ld_use_hz && !jmp_id;
  end

  // Sequencer state: remaining register mask and micro-op counter
  always_ff @(posedge clk) begin
    if (clr || br_taken_ex) begin
      // Reset, or a taken branch squashing the younger LM/SM
      state <= IDLE;
      mask  <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok && imm_multi) begin
            state <= SEQ;
            mask  <= lmsm_imm_8 & (lmsm_imm_8 - MASK_W'(1));
            idx   <= K_W'(1);
          end
        end
        SEQ: begin
          if (mask_one || (mask == '0)) begin
            state <= IDLE;
            mask  <= '0;
            idx   <= '0;
          end else begin
            mask <= mask & (mask - MASK_W'(1));
            idx  <= idx + K_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          mask  <= '0;
          idx   <= '0;
        end
      endcase
    end
  end

  // Stage-register control and micro-op outputs, highest priority first
  always_comb begin
    pc_en       = 1'b1;
    en_f2d      = 1'b1;
    en_d2e      = 1'b1;
    en_e2m      = 1'b1;
    en_m2w      = 1'b1;
    clr_f2d     = 1'b0;
    clr_d2e     = 1'b0;
    clr_e2m     = 1'b0;
    clr_m2w     = 1'b0;
    k_3         = '0;
    lmsm_idx_3  = '0;
    lmsm_active = 1'b0;
    lmsm_last   = 1'b0;

    if (clr) begin
      // Freeze everything and clear every stage register
      pc_en   = 1'b0;
      en_f2d  = 1'b0;
      en_d2e  = 1'b0;
      en_e2m  = 1'b0;
      en_m2w  = 1'b0;
      clr_f2d = 1'b1;
      clr_d2e = 1'b1;
      clr_e2m = 1'b1;
      clr_m2w = 1'b1;
    end else if (br_taken_ex) begin
      // Flush the two younger stages; PC loads the branch target
      clr_f2d = 1'b1;
      clr_d2e = 1'b1;
    end else if (state == SEQ) begin
      // Continue the LM/SM expansion; hazards from ID are irrelevant here
      k_3         = mask_low;
      lmsm_idx_3  = idx;
      lmsm_active = 1'b1;
      if (mask_one) begin
        lmsm_last = 1'b1;
      end else begin
        pc_en  = 1'b0;
        en_f2d = 1'b0;
      end
    end else if (ld_use_hz) begin
      // Hold PC and IF/ID, inject a bubble into ID/EX
      pc_en   = 1'b0;
      en_f2d  = 1'b0;
      clr_d2e = 1'b1;
    end else if (jmp_id) begin
      // Discard the wrong-path fetch behind the jump
      clr_f2d = 1'b1;
    end else if (lmsm_start && (lmsm_imm_8 != '0)) begin
      // First micro-op; stall fetch only if more micro-ops follow
      k_3         = imm_low;
      lmsm_active = 1'b1;
      if (imm_one) begin
        lmsm_last = 1'b1;
      end else begin
        pc_en  = 1'b0;
        en_f2d = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed per-cycle vectors push the
// hand-computed expected output word; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       clr;
  logic       ld_use_hz;
  logic       jmp_id;
  logic       br_taken_ex;
  logic       lmsm_start;
  logic [7:0] lmsm_imm_8;
  logic       pc_en;
  logic       en_f2d, en_d2e, en_e2m, en_m2w;
  logic       clr_f2d, clr_d2e, clr_e2m, clr_m2w;
  logic [2:0] k_3;
  logic [2:0] lmsm_idx_3;
  logic       lmsm_active;
  logic       lmsm_last;

  pipe_hazard_ctrl #(.K_W(3)) dut (
    .clk         (clk),
    .clr         (clr),
    .ld_use_hz   (ld_use_hz),
    .jmp_id      (jmp_id),
    .br_taken_ex (br_taken_ex),
    .lmsm_start  (lmsm_start),
    .lmsm_imm_8  (lmsm_imm_8),
    .pc_en       (pc_en),
    .en_f2d      (en_f2d),
    .en_d2e      (en_d2e),
    .en_e2m      (en_e2m),
    .en_m2w      (en_m2w),
    .clr_f2d     (clr_f2d),
    .clr_d2e     (clr_d2e),
    .clr_e2m     (clr_e2m),
    .clr_m2w     (clr_m2w),
    .k_3         (k_3),
    .lmsm_idx_3  (lmsm_idx_3),
    .lmsm_active (lmsm_active),
    .lmsm_last   (lmsm_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_en, en[f2d,d2e,e2m,m2w], clr[f2d,d2e,e2m,m2w], k, idx, active, last}
  logic [16:0] act;
  assign act = {pc_en, en_f2d, en_d2e, en_e2m, en_m2w,
                clr_f2d, clr_d2e, clr_e2m, clr_m2w,
                k_3, lmsm_idx_3, lmsm_active, lmsm_last};

  typedef struct {
    logic [16:0] e;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [16:0] mk(input logic pc, input logic [3:0] en,
                                     input logic [3:0] cl, input logic [2:0] k,
                                     input logic [2:0] ix, input logic a,
                                     input logic l);
    return {pc, en, cl, k, ix, a, l};
  endfunction

  // Drive one cycle of inputs just after the rising edge and log the expectation
  task automatic step(input logic c, input logic br, input logic ld,
                      input logic jmp, input logic st, input logic [7:0] imm,
                      input logic [16:0] e, input string name);
    exp_t x;
    @(posedge clk);
    #1;
    clr         = c;
    br_taken_ex = br;
    ld_use_hz   = ld;
    jmp_id      = jmp;
    lmsm_start  = st;
    lmsm_imm_8  = imm;
    x.e    = e;
    x.name = name;
    q.push_back(x);
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      n_chk++;
      if (act !== cur.e) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b", cur.name, act, cur.e);
      end
    end
  end

  logic [16:0] DEF, RST, LDU, JMP, BRF;

  initial begin
    clr = 1'b1; br_taken_ex = 1'b0; ld_use_hz = 1'b0; jmp_id = 1'b0;
    lmsm_start = 1'b0; lmsm_imm_8 = 8'h00;

    DEF = mk(1'b1, 4'b1111, 4'b0000, 3'd0, 3'd0, 1'b0, 1'b0);
    RST = mk(1'b0, 4'b0000, 4'b1111, 3'd0, 3'd0, 1'b0, 1'b0);
    LDU = mk(1'b0, 4'b0111, 4'b0100, 3'd0, 3'd0, 1'b0, 1'b0);
    JMP = mk(1'b1, 4'b1111, 4'b1000, 3'd0, 3'd0, 1'b0, 1'b0);
    BRF = mk(1'b1, 4'b1111, 4'b1100, 3'd0, 3'd0, 1'b0, 1'b0);

    // Reset held two cycles, then defaults
    step(1, 0, 0, 0, 0, 8'h00, RST, "reset_c1");
    step(1, 0, 0, 0, 0, 8'h00, RST, "reset_c2");
    step(0, 0, 0, 0, 0, 8'h00, DEF, "post_reset");

    // Load-use stall for one cycle
    step(0, 0, 1, 0, 0, 8'h00, LDU, "ld_use");
    step(0, 0, 0, 0, 0, 8'h00, DEF, "ld_use_after");

    // Jump in ID
    step(0, 0, 0, 1, 0, 8'h00, JMP, "jmp");
    step(0, 0, 0, 0, 0, 8'h00, DEF, "jmp_after");

    // LM with mask A4: k = 2,5,7
    step(0, 0, 0, 0, 1, 8'hA4, mk(0, 4'b0111, 4'b0000, 3'd2, 3'd0, 1, 0), "a4_op0");
    step(0, 0, 0, 0, 1, 8'hA4, mk(0, 4'b0111, 4'b0000, 3'd5, 3'd1, 1, 0), "a4_op1");
    step(0, 0, 0, 0, 1, 8'hA4, mk(1, 4'b1111, 4'b0000, 3'd7, 3'd2, 1, 1), "a4_op2");
    step(0, 0, 0, 0, 0, 8'h00, DEF, "a4_after");

    // Empty mask is a NOP; single-bit mask is one cycle
    step(0, 0, 0, 0, 1, 8'h00, DEF, "imm00_nop");
    step(0, 0, 0, 0, 1, 8'h80, mk(1, 4'b1111, 4'b0000, 3'd7, 3'd0, 1, 1), "imm80_single");
    step(0, 0, 0, 0, 0, 8'h00, DEF, "imm80_after");

    // FF: ld_use/jmp ignored in SEQ, branch aborts on 2nd SEQ cycle
    step(0, 0, 0, 0, 1, 8'hFF, mk(0, 4'b0111, 4'b0000, 3'd0, 3'd0, 1, 0), "ff_op0");
    step(0, 0, 1, 1, 1, 8'hFF, mk(0, 4'b0111, 4'b0000, 3'd1, 3'd1, 1, 0), "ff_seq_hz_ignored");
    step(0, 1, 0, 0, 1, 8'hFF, BRF, "ff_branch_abort");
    step(0, 0, 0, 0, 0, 8'h00, DEF, "ff_after_abort");

    // Deferred start behind a load-use stall, then mask 03 from a clean idx
    step(0, 0, 1, 0, 1, 8'h03, LDU, "imm03_ld_stall");
    step(0, 0, 0, 0, 1, 8'h03, mk(0, 4'b0111, 4'b0000, 3'd0, 3'd0, 1, 0), "imm03_op0");
    step(0, 0, 0, 0, 1, 8'h03, mk(1, 4'b1111, 4'b0000, 3'd1, 3'd1, 1, 1), "imm03_op1");
    step(0, 0, 0, 0, 0, 8'h00, DEF, "imm03_after");

    // Reset in the middle of a sequence
    step(0, 0, 0, 0, 1, 8'h0F, mk(0, 4'b0111, 4'b0000, 3'd0, 3'd0, 1, 0), "0f_op0");
    step(1, 0, 0, 0, 1, 8'h0F, RST, "0f_reset_mid");
    step(0, 0, 0, 0, 0, 8'h00, DEF, "0f_after_reset");
    step(0, 0, 0, 0, 1, 8'h06, mk(0, 4'b0111, 4'b0000, 3'd1, 3'd0, 1, 0), "06_op0");
    step(0, 0, 0, 0, 1, 8'h06, mk(1, 4'b1111, 4'b0000, 3'd2, 3'd1, 1, 1), "06_op1");

    // Branch together with start wins; no sequence begins
    step(0, 1, 0, 0, 1, 8'h03, BRF, "br_with_start");
    step(0, 0, 0, 0, 0, 8'h00, DEF, "br_with_start_after");
    // Branch outranks load-use
    step(0, 1, 1, 0, 0, 8'h00, BRF, "br_over_ld_use");
    step(0, 0, 0, 0, 0, 8'h00, DEF, "final_idle");

    @(posedge clk);
    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush and multi-cycle sequencing controller for the 5-stage pipeline. Drives the `enable`/`clr` pair of all four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable. Resolves load-use stalls, branch/jump flushes and LM/SM expansion. For LM/SM it emits one micro-op per cycle with register index `k_3`, and that index then travels down the pipe as the `k` field of the stage registers.

## Interface
- `K_W`, 3: register index width; mask width is 2**K_W (8).
- `clk`  in  1  pipeline clock, all state updates on rising edge
- `clr`  in  1  synchronous active-high reset
- `ld_use_hz`  in  1  ID instruction reads the destination of a load in EX (from decoder compare)
- `jmp_id`  in  1  unconditional jump resolved in ID this cycle
- `br_taken_ex`  in  1  conditional branch resolved taken in EX this cycle
- `lmsm_start`  in  1  instruction in ID is LM or SM
- `lmsm_imm_8`  in  8  register-select mask from the LM/SM instruction in ID
- `pc_en`  out  1  PC write enable
- `en_f2d`, `en_d2e`, `en_e2m`, `en_m2w`  out  1 each  stage register enables
- `clr_f2d`, `clr_d2e`, `clr_e2m`, `clr_m2w`  out  1 each  stage register synchronous clears (bubble insert)
- `k_3`  out  K_W  register index of the current LM/SM micro-op
- `lmsm_idx_3`  out  K_W  sequence number of the micro-op (0..n-1), used for the address offset
- `lmsm_active`  out  1  the current ID output is an LM/SM micro-op
- `lmsm_last`  out  1  the current micro-op is the final one of its instruction

## Operation
- State: FSM {IDLE, SEQ}, plus an 8-bit `mask` register and a K_W-bit `idx` counter. All outputs are combinational from state and inputs.
- Default (IDLE, no events): all `en_*`=1, all `clr_*`=0, `pc_en`=1, `k_3`=0, `lmsm_*`=0.
- Priority, highest first: `clr` > `br_taken_ex` > `ld_use_hz` (IDLE only) > `jmp_id` (IDLE only) > LM/SM sequencing.
- `clr`:
  - outputs: all `clr_*`=1, all `en_*`=0, `pc_en`=0, `k_3`/`lmsm_*`=0.
  - next: state IDLE, `mask`=0, `idx`=0.
- `br_taken_ex`:
  - outputs: `clr_f2d`=`clr_d2e`=1, all `en_*`=1, `pc_en`=1 (PC loads target).
  - next: state IDLE, `mask`=0, `idx`=0. An in-progress LM/SM is aborted, since it is younger than the branch.
- `ld_use_hz` in IDLE:
  - outputs: `pc_en`=0, `en_f2d`=0 (hold IF/ID), `clr_d2e`=1 (bubble), `en_e2m`=`en_m2w`=1.
  - LM/SM start is deferred. IF/ID is held, so `lmsm_start` reappears next cycle.
- `jmp_id` in IDLE: `clr_f2d`=1, `pc_en`=1. `jmp_id` and `lmsm_start` are mutually exclusive by decode.
- LM/SM start, in IDLE with `lmsm_start`=1. Let `p` = lowest set bit of `lmsm_imm_8`:
  - popcount 0: treated as a NOP; `lmsm_active`=0, no stall.
  - popcount 1: `k_3`=p, `lmsm_idx_3`=0, `lmsm_active`=`lmsm_last`=1, no stall, stay IDLE.
  - popcount ≥2: `k_3`=p, `lmsm_idx_3`=0, `lmsm_active`=1, `pc_en`=0, `en_f2d`=0. Next: `mask`=imm with bit p cleared, `idx`=1, state SEQ.
- SEQ. Let `p` = lowest set bit of `mask`:
  - outputs: `k_3`=p, `lmsm_idx_3`=`idx`, `lmsm_active`=1, `en_d2e`=`en_e2m`=`en_m2w`=1.
  - `ld_use_hz` and `jmp_id` are ignored.
  - if `mask` has exactly one bit set: `lmsm_last`=1, `pc_en`=1, `en_f2d`=1; next state IDLE, `mask`=0, `idx`=0.
  - else: `pc_en`=0, `en_f2d`=0; next `mask` clears bit p, `idx`=`idx`+1.
- `idx` never wraps: at most 8 micro-ops, max value 7.

## Timing
- Zero-cycle control latency: outputs respond combinationally to inputs in the same cycle. Stage registers and the PC act on the next rising edge.
- An LM/SM with n set bits (n≥1) occupies ID for n cycles and stalls fetch for n-1 cycles. Micro-ops issue back-to-back, with `k_3` in ascending bit order.
- A load-use stall costs exactly 1 cycle per assertion.
- Reset mid-SEQ: the sequence is discarded and the first cycle after `clr` deasserts is IDLE default.
- Branch in the same cycle as `lmsm_start` or SEQ: the flush wins, and no `lmsm_active` is asserted that cycle.

## Test plan
- Reset: `clr`=1 for 2 cycles → all `clr_*`=1, `en_*`=0, `pc_en`=0, `k_3`=0. Cycle after release → all `en_*`=1, `pc_en`=1.
- Load-use: `ld_use_hz`=1 for 1 cycle → `pc_en`=0, `en_f2d`=0, `clr_d2e`=1 that cycle; defaults on the following cycle.
- LM `imm`=8'hA4 → `k_3`=2,5,7 on 3 consecutive cycles, `lmsm_idx_3`=0,1,2, `lmsm_last` on cycle 3 only, `pc_en`=0,0,1.
- `imm`=8'h00 → no stall, `lmsm_active`=0. `imm`=8'h80 → single cycle, `k_3`=7, `lmsm_last`=1, `pc_en`=1.
- `imm`=8'hFF, `br_taken_ex`=1 on the 2nd SEQ cycle → `clr_f2d`=`clr_d2e`=1, `lmsm_active`=0, then IDLE with `mask` and `idx` at 0.
- `lmsm_start` with `ld_use_hz`=1 (`imm`=8'h03) → stall cycle with `lmsm_active`=0, then `k_3`=0, then `k_3`=1 with `lmsm_last`=1.
